// File: rtl/ysyx_23060203_sram_resp.sv
// AXI4-lite style data memory responder with independent read/write FSMs and LAT-cycle response delay.
// Optional YSYX_23060203_SRAM_RAND_DELAY_EN adds 0..7 pseudo-random extra wait cycles per request.
module ysyx_23060203_sram_resp #(
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE       = 32'h8000_0000,
    parameter int          LAT        = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = $clog2(LAT + 8) + 1;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

    function automatic logic addr_ok(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a >= BASE) && ((off >> (DEPTH_LOG2 + 2)) == 32'd0);
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] addr_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off[DEPTH_LOG2+1:2];
    endfunction

    logic [31:0] mem [0:DEPTH-1];

    r_state_t             r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic                 r_ok;

    w_state_t             w_state;
    logic [CNT_W-1:0]     w_cnt;
    logic [DEPTH_LOG2-1:0] aw_idx;
    logic                 aw_ok;
    logic [31:0]          w_data;
    logic [3:0]           w_strb;

    logic [CNT_W-1:0] dly_load;

`ifdef YSYX_23060203_SRAM_RAND_DELAY_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    // Right-shifting Fibonacci form of taps 16,14,13,11.
    assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) lfsr <= 16'hACE1;
        else       lfsr <= {lfsr_fb, lfsr[15:1]};
    end

    assign dly_load = CNT_W'(LAT) + CNT_W'(lfsr[2:0]);
`else
    assign dly_load = CNT_W'(LAT);
`endif

    logic [DEPTH_LOG2-1:0] rd_idx;
    logic                  rd_ok;
    logic [31:0]           rd_word;

    // With zero delay the read samples memory in the accept cycle, straight from araddr.
    always_comb begin
        rd_idx = r_idx;
        rd_ok  = r_ok;
        if (r_state == R_IDLE) begin
            rd_idx = addr_idx(araddr);
            rd_ok  = addr_ok(araddr);
        end
    end

    assign rd_word = mem[rd_idx];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= R_IDLE;
            arready <= 1'b1;
            rvalid  <= 1'b0;
            rdata   <= 32'd0;
            rresp   <= 2'b00;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_ok    <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: if (arvalid) begin
                    arready <= 1'b0;
                    r_idx   <= rd_idx;
                    r_ok    <= rd_ok;
                    r_cnt   <= dly_load;
                    if (dly_load == '0) begin
                        rdata   <= rd_ok ? rd_word : 32'd0;
                        rresp   <= rd_ok ? 2'b00 : 2'b10;
                        rvalid  <= 1'b1;
                        r_state <= R_RESP;
                    end else begin
                        r_state <= R_WAIT;
                    end
                end
                R_WAIT: if (r_cnt == CNT_W'(1)) begin
                    rdata   <= rd_ok ? rd_word : 32'd0;
                    rresp   <= rd_ok ? 2'b00 : 2'b10;
                    rvalid  <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= R_RESP;
                end else begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                R_RESP: if (rready) begin
                    rvalid  <= 1'b0;
                    arready <= 1'b1;
                    r_state <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    logic                  aw_hs, w_hs, aw_have, w_have, w_go, wr_commit;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic                  wr_ok;
    logic [31:0]           wr_data;
    logic [3:0]            wr_strb;

    assign aw_hs   = awvalid & awready;
    assign w_hs    = wvalid & wready;
    // In W_IDLE a dropped ready means that channel's beat is already held.
    assign aw_have = aw_hs | ~awready;
    assign w_have  = w_hs | ~wready;
    assign w_go    = (w_state == W_IDLE) && aw_have && w_have;

    always_comb begin
        wr_idx  = aw_hs ? addr_idx(awaddr) : aw_idx;
        wr_ok   = aw_hs ? addr_ok(awaddr) : aw_ok;
        wr_data = w_hs ? wdata : w_data;
        wr_strb = w_hs ? wstrb : w_strb;
    end

    assign wr_commit = ~reset && wr_ok &&
                       ((w_go && dly_load == '0) ||
                        (w_state == W_WAIT && w_cnt == CNT_W'(1)));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w_state <= W_IDLE;
            awready <= 1'b1;
            wready  <= 1'b1;
            bvalid  <= 1'b0;
            bresp   <= 2'b00;
            w_cnt   <= '0;
            aw_idx  <= '0;
            aw_ok   <= 1'b0;
            w_data  <= 32'd0;
            w_strb  <= 4'd0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_idx  <= wr_idx;
                        aw_ok   <= wr_ok;
                        awready <= 1'b0;
                    end
                    if (w_hs) begin
                        w_data <= wr_data;
                        w_strb <= wr_strb;
                        wready <= 1'b0;
                    end
                    if (w_go) begin
                        w_cnt <= dly_load;
                        if (dly_load == '0) begin
                            bvalid  <= 1'b1;
                            bresp   <= wr_ok ? 2'b00 : 2'b10;
                            w_state <= W_RESP;
                        end else begin
                            w_state <= W_WAIT;
                        end
                    end
                end
                W_WAIT: if (w_cnt == CNT_W'(1)) begin
                    bvalid  <= 1'b1;
                    bresp   <= wr_ok ? 2'b00 : 2'b10;
                    w_cnt   <= '0;
                    w_state <= W_RESP;
                end else begin
                    w_cnt <= w_cnt - CNT_W'(1);
                end
                W_RESP: if (bready) begin
                    bvalid  <= 1'b0;
                    awready <= 1'b1;
                    wready  <= 1'b1;
                    w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Memory is never reset; a read sampling alongside a commit sees the old word.
    always_ff @(posedge clock) begin
        if (wr_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060203_sram_resp.sv
// Self-checking bench for ysyx_23060203_sram_resp: vector table plus corner-case sequences.
module tb_ysyx_23060203_sram_resp;

    localparam int DEPTH_LOG2 = 12;
    localparam int LAT        = 2;

    logic        clock, reset;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  rresp, bresp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    ysyx_23060203_sram_resp #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .BASE      (32'h8000_0000),
        .LAT       (LAT)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .araddr (araddr),
        .arvalid(arvalid),
        .arready(arready),
        .rdata  (rdata),
        .rresp  (rresp),
        .rvalid (rvalid),
        .rready (rready),
        .awaddr (awaddr),
        .awvalid(awvalid),
        .awready(awready),
        .wdata  (wdata),
        .wstrb  (wstrb),
        .wvalid (wvalid),
        .wready (wready),
        .bresp  (bresp),
        .bvalid (bvalid),
        .bready (bready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    typedef struct {
        bit          wr;
        logic [31:0] data;
        logic [1:0]  resp;
    } sb_t;

    vec_t vecs [16];
    sb_t  sb [$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
        sb_t e;
        int  n;
        e.wr = 1'b0; e.data = ed; e.resp = er;
        sb.push_back(e);
        araddr  = a;
        arvalid = 1'b1;
        @(negedge clock);
        arvalid = 1'b0;
        chk("rd_arready_drop", 32'(arready), 32'd0);
        n = 1;
        while (!rvalid && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("rd_latency", 32'(n), 32'(LAT + 1));
        e = sb.pop_front();
        chk("rd_kind", 32'(e.wr), 32'd0);
        chk("rd_data", rdata, e.data);
        chk("rd_resp", 32'(rresp), 32'(e.resp));
        rready = 1'b1;
        @(negedge clock);
        rready = 1'b0;
        chk("rd_rvalid_clear", 32'(rvalid), 32'd0);
        chk("rd_arready_back", 32'(arready), 32'd1);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] er);
        sb_t e;
        int  n;
        e.wr = 1'b1; e.data = 32'd0; e.resp = er;
        sb.push_back(e);
        awaddr  = a;
        wdata   = d;
        wstrb   = s;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        @(negedge clock);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        chk("wr_ready_drop", 32'({awready, wready}), 32'd0);
        n = 1;
        while (!bvalid && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("wr_latency", 32'(n), 32'(LAT + 1));
        e = sb.pop_front();
        chk("wr_kind", 32'(e.wr), 32'd1);
        chk("wr_bresp", 32'(bresp), 32'(e.resp));
        bready = 1'b1;
        @(negedge clock);
        bready = 1'b0;
        chk("wr_bvalid_clear", 32'(bvalid), 32'd0);
        chk("wr_ready_back", 32'({awready, wready}), 32'd3);
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_arready"}, 32'(arready), 32'd1);
        chk({nm, "_awready"}, 32'(awready), 32'd1);
        chk({nm, "_wready"},  32'(wready),  32'd1);
        chk({nm, "_rvalid"},  32'(rvalid),  32'd0);
        chk({nm, "_bvalid"},  32'(bvalid),  32'd0);
    endtask

    initial begin
        int          n;
        logic [31:0] held;

        vecs[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         2'b00};
        vecs[1]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'b00};
        vecs[2]  = '{1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, 32'h0,         2'b00};
        vecs[3]  = '{1'b1, 32'h8000_0020, 32'hAABB_CCDD, 4'h5, 32'h0,         2'b00};
        vecs[4]  = '{1'b0, 32'h8000_0020, 32'h0,         4'h0, 32'h11BB_33DD, 2'b00};
        vecs[5]  = '{1'b1, 32'h8000_0000, 32'h0102_0304, 4'hF, 32'h0,         2'b00};
        vecs[6]  = '{1'b1, 32'h8000_4000, 32'h1234_5678, 4'hF, 32'h0,         2'b10};
        vecs[7]  = '{1'b0, 32'h8000_4000, 32'h0,         4'h0, 32'h0,         2'b10};
        vecs[8]  = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'h0102_0304, 2'b00};
        vecs[9]  = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 32'h0,         2'b10};
        vecs[10] = '{1'b1, 32'h8000_3FFC, 32'hCAFE_F00D, 4'hF, 32'h0,         2'b00};
        vecs[11] = '{1'b1, 32'h8000_3FFC, 32'hFFFF_FFFF, 4'h0, 32'h0,         2'b00};
        vecs[12] = '{1'b0, 32'h8000_3FFE, 32'h0,         4'h0, 32'hCAFE_F00D, 2'b00};
        vecs[13] = '{1'b0, 32'h8000_0013, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'b00};
        vecs[14] = '{1'b1, 32'h8000_0040, 32'h0,         4'hF, 32'h0,         2'b00};
        vecs[15] = '{1'b1, 32'h8000_0050, 32'hA5A5_A5A5, 4'hF, 32'h0,         2'b00};

        reset = 1'b1;
        araddr = '0; arvalid = 0; rready = 0;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        @(negedge clock);
        @(negedge clock);
        chk_idle("rst");
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_resp", 32'({rresp, bresp}), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk_idle("post_rst");

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp);
            else            do_read(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp);
        end

        // W beat three cycles ahead of AW.
        wdata = 32'h1357_9BDF; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clock);
        wvalid = 1'b0;
        chk("wfirst_wready", 32'(wready), 32'd0);
        chk("wfirst_awready", 32'(awready), 32'd1);
        @(negedge clock);
        chk("wfirst_bvalid1", 32'(bvalid), 32'd0);
        @(negedge clock);
        chk("wfirst_bvalid2", 32'(bvalid), 32'd0);
        awaddr = 32'h8000_0030; awvalid = 1'b1;
        @(negedge clock);
        awvalid = 1'b0;
        n = 1;
        while (!bvalid && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("wfirst_latency", 32'(n), 32'(LAT + 1));
        chk("wfirst_bresp", 32'(bresp), 32'd0);
        bready = 1'b1;
        @(negedge clock);
        bready = 1'b0;
        do_read(32'h8000_0030, 32'h1357_9BDF, 2'b00);

        // Read backpressure while the write channel completes a transaction.
        araddr = 32'h8000_0010; arvalid = 1'b1;
        @(negedge clock);
        arvalid = 1'b0;
        n = 1;
        while (!rvalid && n < 40) begin
            @(negedge clock);
            n++;
        end
        held = rdata;
        chk("bp_data", held, 32'hDEAD_BEEF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("bp_rvalid", 32'(rvalid), 32'd1);
            chk("bp_rdata", rdata, held);
            chk("bp_arready", 32'(arready), 32'd0);
        end
        do_write(32'h8000_0060, 32'h7777_0000, 4'hC, 2'b00);
        chk("bp_rvalid_after_wr", 32'(rvalid), 32'd1);
        chk("bp_rdata_after_wr", rdata, held);
        rready = 1'b1;
        @(negedge clock);
        rready = 1'b0;
        chk("bp_rvalid_clear", 32'(rvalid), 32'd0);
        chk("bp_arready_back", 32'(arready), 32'd1);

        // Read and write to one word accepted together: read sees the old word.
        araddr = 32'h8000_0040; awaddr = 32'h8000_0040;
        wdata = 32'h55; wstrb = 4'hF;
        arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clock);
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        n = 1;
        while (!(rvalid && bvalid) && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("coll_latency", 32'(n), 32'(LAT + 1));
        chk("coll_rdata_old", rdata, 32'h0);
        chk("coll_bresp", 32'(bresp), 32'd0);
        rready = 1'b1; bready = 1'b1;
        @(negedge clock);
        rready = 1'b0; bready = 1'b0;
        do_read(32'h8000_0040, 32'h55, 2'b00);

        // Asynchronous reset while both channels wait.
        araddr = 32'h8000_0050; awaddr = 32'h8000_0050;
        wdata = 32'h0BAD_0BAD; wstrb = 4'hF;
        arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clock);
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        chk("abort_pre_ready", 32'({arready, awready, wready}), 32'd0);
        #2 reset = 1'b1;
        #1;
        chk_idle("abort");
        chk("abort_rdata", rdata, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        do_read(32'h8000_0050, 32'hA5A5_A5A5, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
